// File: rtl/extbus_pkg.sv
// Shared definitions for the external SRAM bus controller: FSM states,
// config register offsets and PAGE register bit positions.
package extbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_END  = 2'd2
  } state_t;

  localparam logic [1:0] REG_PAGE    = 2'd0;
  localparam logic [1:0] REG_CPUWAIT = 2'd1;
  localparam logic [1:0] REG_CHWAIT  = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int PAGE_WP = 4;
  localparam int PAGE_EN = 3;
  localparam logic [2:0] PAGE_WINDOW = 3'b110;

  // A write-protected bank never takes CPU writes; they fall through to the low bank.
  function automatic logic page_hit(input logic [4:0] page, input logic [15:0] addr,
                                    input logic rd);
    return page[PAGE_EN] && (addr[15:13] == PAGE_WINDOW) && !(page[PAGE_WP] && !rd);
  endfunction

endpackage

// File: rtl/extbus_if.sv
// Bundle of CPU, fetch-channel, config-port and SRAM pad signals around extbus_ctrl.
// The controller uses the slave modport; the surrounding system uses master.
interface extbus_if #(
  parameter int NCH    = 2,
  parameter int EXT_AW = 17
);
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_rw;
  logic              cpu_req;
  logic [7:0]        cpu_rdata;
  logic              cpu_done;
  logic              cpu_hold;

  logic              cs;
  logic [1:0]        AD;
  logic [7:0]        DI;
  logic              rw;
  logic [7:0]        DO;

  logic [NCH-1:0]    ch_req;
  logic [NCH*16-1:0] ch_addr;
  logic [NCH-1:0]    ch_ack;
  logic [7:0]        ch_rdata;

  logic [EXT_AW-1:0] ext_ad;
  logic [7:0]        ext_dq_i;
  logic [7:0]        ext_dq_o;
  logic              ext_dq_oe;
  logic              ext_oe_n;
  logic              ext_we_n;
  logic              ext_cs;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rw, cpu_req,
    output cpu_rdata, cpu_done, cpu_hold,
    input  cs, AD, DI, rw,
    output DO,
    input  ch_req, ch_addr,
    output ch_ack, ch_rdata,
    output ext_ad, ext_dq_o, ext_dq_oe, ext_oe_n, ext_we_n, ext_cs,
    input  ext_dq_i
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_rw, cpu_req,
    input  cpu_rdata, cpu_done, cpu_hold,
    output cs, AD, DI, rw,
    input  DO,
    output ch_req, ch_addr,
    input  ch_ack, ch_rdata,
    input  ext_ad, ext_dq_o, ext_dq_oe, ext_oe_n, ext_we_n, ext_cs,
    output ext_dq_i
  );

endinterface

// File: rtl/extbus_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the granted requester when advance is strobed.
module rr_arb #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic          found;
  int            pos;

  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N) pos = pos - N;
      idx = PW'(pos);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/extbus_ctrl.sv
// External async SRAM controller: arbitrates CPU against read-only fetch
// channels, inserts wait states, applies banked paging and exposes config regs.
module extbus_ctrl
  import extbus_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int EXT_AW = 17,
  parameter int PAGE_W = 3,
  parameter int WAIT_W = 3
) (
  input logic     clk,
  input logic     rst,
  extbus_if.slave bus
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t            state;
  logic [4:0]        page_reg;
  logic [WAIT_W-1:0] cpu_wait;
  logic [WAIT_W-1:0] ch_wait;
  logic [WAIT_W-1:0] cnt;
  logic              owner_ch;
  logic [PW-1:0]     last_ch;
  logic [NCH-1:0]    cur_grant;
  logic              acc_rd;

  logic [NCH-1:0]    grant;
  logic [PW-1:0]     grant_idx;
  logic              cpu_elig;
  logic              ch_win;
  logic [15:0]       sel_addr;
  logic [EXT_AW-1:0] cpu_ext_ad;
  logic              unused_di;

  assign cpu_elig      = bus.cpu_req & ~bus.cpu_done;
  // Channels take the bus whenever the CPU had it last, so both sides alternate under load.
  assign ch_win        = (|bus.ch_req) & (~owner_ch | ~cpu_elig);
  assign sel_addr      = bus.ch_addr[int'(grant_idx)*16 +: 16];
  assign cpu_ext_ad    = page_hit(page_reg, bus.cpu_addr, bus.cpu_rw)
                         ? EXT_AW'({1'b1, page_reg[PAGE_W-1:0], bus.cpu_addr[12:0]})
                         : EXT_AW'({1'b0, bus.cpu_addr});
  assign bus.cpu_hold  = bus.cpu_req & ~bus.cpu_done;
  assign unused_di     = ^bus.DI[7:5];

  rr_arb #(.N(NCH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.ch_req),
    .advance   (state == ST_IDLE && ch_win),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      page_reg <= '0;
      cpu_wait <= '0;
      ch_wait  <= '0;
    end else if (bus.cs && !bus.rw) begin
      case (bus.AD)
        REG_PAGE:    page_reg <= bus.DI[4:0];
        REG_CPUWAIT: cpu_wait <= bus.DI[WAIT_W-1:0];
        REG_CHWAIT:  ch_wait  <= bus.DI[WAIT_W-1:0];
        default:     ;
      endcase
    end
  end

  always_comb begin
    bus.DO = '0;
    case (bus.AD)
      REG_PAGE:    bus.DO = {3'b000, page_reg};
      REG_CPUWAIT: bus.DO = 8'(cpu_wait);
      REG_CHWAIT:  bus.DO = 8'(ch_wait);
      default:     bus.DO = {state != ST_IDLE, owner_ch, 4'b0000, 2'(last_ch)};
    endcase
  end

  // Address and write data stay on the pads through END to give the SRAM write hold time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      owner_ch      <= 1'b0;
      last_ch       <= '0;
      cur_grant     <= '0;
      acc_rd        <= 1'b1;
      bus.ext_cs    <= 1'b0;
      bus.ext_oe_n  <= 1'b1;
      bus.ext_we_n  <= 1'b1;
      bus.ext_dq_oe <= 1'b0;
      bus.ext_dq_o  <= '0;
      bus.ext_ad    <= '0;
      bus.cpu_done  <= 1'b0;
      bus.ch_ack    <= '0;
      bus.cpu_rdata <= '0;
      bus.ch_rdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ch_win) begin
            state         <= ST_ACC;
            owner_ch      <= 1'b1;
            last_ch       <= grant_idx;
            cur_grant     <= grant;
            acc_rd        <= 1'b1;
            cnt           <= ch_wait;
            bus.ext_ad    <= EXT_AW'({1'b0, sel_addr});
            bus.ext_cs    <= 1'b1;
            bus.ext_oe_n  <= 1'b0;
            bus.ext_we_n  <= 1'b1;
            bus.ext_dq_oe <= 1'b0;
          end else if (cpu_elig) begin
            state         <= ST_ACC;
            owner_ch      <= 1'b0;
            acc_rd        <= bus.cpu_rw;
            cnt           <= cpu_wait;
            bus.ext_ad    <= cpu_ext_ad;
            bus.ext_cs    <= 1'b1;
            bus.ext_oe_n  <= ~bus.cpu_rw;
            bus.ext_we_n  <= bus.cpu_rw;
            bus.ext_dq_o  <= bus.cpu_wdata;
            bus.ext_dq_oe <= ~bus.cpu_rw;
          end
        end
        ST_ACC: begin
          if (cnt == '0) begin
            state        <= ST_END;
            bus.ext_cs   <= 1'b0;
            bus.ext_oe_n <= 1'b1;
            bus.ext_we_n <= 1'b1;
            if (owner_ch) begin
              bus.ch_ack   <= cur_grant;
              bus.ch_rdata <= bus.ext_dq_i;
            end else begin
              bus.cpu_done <= 1'b1;
              if (acc_rd) bus.cpu_rdata <= bus.ext_dq_i;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_END: begin
          state         <= ST_IDLE;
          bus.cpu_done  <= 1'b0;
          bus.ch_ack    <= '0;
          bus.cpu_rdata <= '0;
          bus.ch_rdata  <= '0;
          bus.ext_ad    <= '0;
          bus.ext_dq_o  <= '0;
          bus.ext_dq_oe <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_extbus_ctrl.sv
// Self-checking bench for extbus_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a timeline-level model.
module tb_extbus_ctrl;

  localparam int NCH    = 2;
  localparam int EXT_AW = 17;
  localparam logic [7:0] SALT = 8'h7C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  extbus_if #(.NCH(NCH), .EXT_AW(EXT_AW)) bus ();

  extbus_ctrl #(.NCH(NCH), .EXT_AW(EXT_AW), .PAGE_W(3), .WAIT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The SRAM returns a fixed function of the address it is given.
  function automatic logic [7:0] sram_fn(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ SALT;
  endfunction
  assign bus.ext_dq_i = sram_fn(bus.ext_ad);

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each access is a timeline of (wait+1) strobe clocks, one
  // END clock, then one idle clock before the next arbitration.
  bit          m_valid = 0;
  bit          m_busy = 0;
  int          m_cyc = 0, m_len = 1;
  bit          m_is_ch = 0, m_rd = 1, m_owner_ch = 0;
  int          m_ch = 0, m_last_ch = 0, m_ptr = 0;
  logic [16:0] m_addr = '0;
  logic [7:0]  m_wdata = '0;
  logic [4:0]  m_page = '0;
  int          m_cw = 0, m_chw = 0;

  function automatic bit m_end();
    return m_busy && (m_cyc == m_len + 1);
  endfunction

  always @(posedge clk) begin
    bit cpu_elig, found, pg;
    int k;
    if (rst) begin
      m_valid = 1; m_busy = 0; m_cyc = 0; m_owner_ch = 0; m_last_ch = 0; m_ptr = 0;
      m_page = '0; m_cw = 0; m_chw = 0;
    end else begin
      if (m_busy) begin
        m_cyc++;
        if (m_cyc > m_len + 1) m_busy = 0;
      end else begin
        cpu_elig = bus.cpu_req && !(m_end() && !m_is_ch);
        if (bus.ch_req != '0 && (!m_owner_ch || !cpu_elig)) begin
          found = 0; k = 0;
          for (int i = 0; i < NCH; i++) begin
            if (!found && bus.ch_req[(m_ptr + i) % NCH]) begin
              found = 1; k = (m_ptr + i) % NCH;
            end
          end
          m_ch = k; m_ptr = (k + 1) % NCH; m_last_ch = k; m_owner_ch = 1;
          m_is_ch = 1; m_rd = 1; m_addr = {1'b0, bus.ch_addr[k*16 +: 16]};
          m_len = m_chw + 1; m_busy = 1; m_cyc = 1;
        end else if (cpu_elig) begin
          pg = m_page[3] && bus.cpu_addr[15:13] == 3'b110 && !(m_page[4] && !bus.cpu_rw);
          m_addr = pg ? {1'b1, m_page[2:0], bus.cpu_addr[12:0]} : {1'b0, bus.cpu_addr};
          m_owner_ch = 0; m_is_ch = 0; m_rd = bus.cpu_rw; m_wdata = bus.cpu_wdata;
          m_len = m_cw + 1; m_busy = 1; m_cyc = 1;
        end
      end
      if (bus.cs && !bus.rw) begin
        case (bus.AD)
          2'd0: m_page = bus.DI[4:0];
          2'd1: m_cw = int'(bus.DI[2:0]);
          2'd2: m_chw = int'(bus.DI[2:0]);
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    bit acc, endp;
    logic [7:0] e_do;
    if (m_valid) begin
      acc  = m_busy && m_cyc <= m_len;
      endp = m_end();
      case (bus.AD)
        2'd0: e_do = {3'b0, m_page};
        2'd1: e_do = 8'(m_cw);
        2'd2: e_do = 8'(m_chw);
        default: e_do = {m_busy, m_owner_ch, 4'b0, 2'(m_last_ch)};
      endcase
      checkOutput("ext_cs", bus.ext_cs, acc);
      checkOutput("ext_oe_n", bus.ext_oe_n, !(acc && m_rd));
      checkOutput("ext_we_n", bus.ext_we_n, !(acc && !m_rd));
      checkOutput("ext_ad", bus.ext_ad, m_busy ? m_addr : 17'h0);
      checkOutput("ext_dq_oe", bus.ext_dq_oe, m_busy && !m_rd);
      if (m_busy && !m_rd) checkOutput("ext_dq_o", bus.ext_dq_o, m_wdata);
      checkOutput("cpu_done", bus.cpu_done, endp && !m_is_ch);
      checkOutput("ch_ack", bus.ch_ack, (endp && m_is_ch) ? (32'd1 << m_ch) : 32'd0);
      checkOutput("cpu_rdata", bus.cpu_rdata, (endp && !m_is_ch && m_rd) ? sram_fn(m_addr) : 8'h0);
      checkOutput("ch_rdata", bus.ch_rdata, (endp && m_is_ch) ? sram_fn(m_addr) : 8'h0);
      checkOutput("cpu_hold", bus.cpu_hold, bus.cpu_req && !(endp && !m_is_ch));
      checkOutput("DO", bus.DO, e_do);
    end
  end

  task automatic cfgWrite(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #2;
    bus.cs = 1; bus.rw = 0; bus.AD = a; bus.DI = d;
    @(posedge clk); #2;
    bus.cs = 0; bus.rw = 1;
  endtask

  task automatic cpuAccess(input logic [15:0] a, input logic r, input logic [7:0] wd,
                           output int hold_n, output int strobe_n, output int dqoe_n,
                           output logic [16:0] ad, output logic [7:0] rd,
                           output logic [7:0] dqo, output bit ok);
    @(posedge clk); #2;
    bus.cpu_addr = a; bus.cpu_rw = r; bus.cpu_wdata = wd; bus.cpu_req = 1;
    hold_n = 0; strobe_n = 0; dqoe_n = 0; ad = '0; rd = '0; dqo = '0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.cpu_hold) hold_n++;
      if (!bus.ext_oe_n || !bus.ext_we_n) begin strobe_n++; ad = bus.ext_ad; end
      if (bus.ext_dq_oe) dqoe_n++;
      if (bus.cpu_done) begin ok = 1; rd = bus.cpu_rdata; dqo = bus.ext_dq_o; end
    end
    @(posedge clk); #2;
    bus.cpu_req = 0;
  endtask

  task automatic applyStimulus();
    @(posedge clk); #2;
    rst = ($urandom_range(0, 299) == 0);
    if (bus.cpu_req ? bus.cpu_done : ($urandom_range(0, 3) == 0)) begin
      bus.cpu_req   = ($urandom_range(0, 3) != 0);
      bus.cpu_addr  = $urandom_range(0, 1) ? 16'($urandom_range(16'hC000, 16'hDFFF)) : 16'($urandom);
      bus.cpu_rw    = 1'($urandom);
      bus.cpu_wdata = 8'($urandom);
    end
    for (int k = 0; k < NCH; k++) begin
      if (bus.ch_req[k] ? bus.ch_ack[k] : ($urandom_range(0, 3) == 0)) begin
        bus.ch_req[k] = ($urandom_range(0, 2) != 0);
        bus.ch_addr[k*16 +: 16] = 16'($urandom);
      end
    end
    bus.AD = 2'($urandom);
    if ($urandom_range(0, 15) == 0) begin
      bus.cs = 1; bus.rw = 0; bus.DI = 8'($urandom);
    end else begin
      bus.cs = 0; bus.rw = 1;
    end
  endtask

  initial begin
    int hold_n, strobe_n, dqoe_n, n, acks;
    logic [16:0] ad;
    logic [7:0]  rd, dqo;
    bit ok;
    int order [5];
    int exp_order [5] = '{0, 2, 1, 2, 0};

    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_rw = 1; bus.cpu_req = 0;
    bus.cs = 0; bus.AD = '0; bus.DI = '0; bus.rw = 1;
    bus.ch_req = '0; bus.ch_addr = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;

    $display("[TB] reset values");
    @(negedge clk);
    checkOutput("rst ext_cs", bus.ext_cs, 0);
    checkOutput("rst ext_oe_n", bus.ext_oe_n, 1);
    checkOutput("rst ext_we_n", bus.ext_we_n, 1);
    checkOutput("rst ext_dq_oe", bus.ext_dq_oe, 0);
    checkOutput("rst ext_ad", bus.ext_ad, 0);
    checkOutput("rst cpu_done", bus.cpu_done, 0);
    checkOutput("rst ch_ack", bus.ch_ack, 0);
    checkOutput("rst cpu_hold", bus.cpu_hold, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2 bus.AD = 2'(i);
      @(negedge clk);
      checkOutput("rst reg read", bus.DO, 8'h00);
    end

    $display("[TB] plain CPU read");
    cpuAccess(16'h1234, 1, 8'h00, hold_n, strobe_n, dqoe_n, ad, rd, dqo, ok);
    checkOutput("t2 done seen", ok, 1);
    checkOutput("t2 ext_ad", ad, 17'h01234);
    checkOutput("t2 oe_n low clks", strobe_n, 1);
    checkOutput("t2 hold clks", hold_n, 2);
    checkOutput("t2 rdata", rd, 8'h5A);

    $display("[TB] paging");
    cfgWrite(2'd0, 8'h0D);
    cpuAccess(16'hC010, 1, 8'h00, hold_n, strobe_n, dqoe_n, ad, rd, dqo, ok);
    checkOutput("t3 paged read ad", ad, 17'h1A010);
    cfgWrite(2'd0, 8'h1D);
    cpuAccess(16'hC010, 0, 8'h33, hold_n, strobe_n, dqoe_n, ad, rd, dqo, ok);
    checkOutput("t3 protected write ad", ad, 17'h0C010);
    cpuAccess(16'hE000, 1, 8'h00, hold_n, strobe_n, dqoe_n, ad, rd, dqo, ok);
    checkOutput("t3 outside window ad", ad, 17'h0E000);
    cfgWrite(2'd0, 8'h00);

    $display("[TB] CPU write with wait states");
    cfgWrite(2'd1, 8'h03);
    cpuAccess(16'h0100, 0, 8'hA5, hold_n, strobe_n, dqoe_n, ad, rd, dqo, ok);
    checkOutput("t4 done seen", ok, 1);
    checkOutput("t4 we_n low clks", strobe_n, 4);
    checkOutput("t4 dq_oe clks", dqoe_n, 5);
    checkOutput("t4 dq_o", dqo, 8'hA5);
    checkOutput("t4 hold clks", hold_n, 5);
    cfgWrite(2'd1, 8'h00);

    $display("[TB] full-load arbitration");
    @(posedge clk); #2;
    bus.ch_addr = {16'h2222, 16'h1111};
    bus.ch_req = 2'b11; bus.cpu_addr = 16'h0040; bus.cpu_rw = 1; bus.cpu_req = 1;
    n = 0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      @(negedge clk);
      if (bus.ch_ack[0])      begin order[n] = 0; n++; end
      else if (bus.ch_ack[1]) begin order[n] = 1; n++; end
      else if (bus.cpu_done)  begin order[n] = 2; n++; end
    end
    @(posedge clk); #2;
    bus.ch_req = '0; bus.cpu_req = 0;
    checkOutput("t5 grant count", n, 5);
    for (int i = 0; i < n; i++) checkOutput("t5 grant order", order[i], exp_order[i]);

    $display("[TB] reset mid-fetch");
    cfgWrite(2'd2, 8'h02);
    @(posedge clk); #2;
    bus.ch_addr[15:0] = 16'h3000; bus.ch_req = 2'b01;
    @(posedge clk);
    @(posedge clk); #2 rst = 1;
    @(negedge clk);
    checkOutput("t6 cs during acc", bus.ext_cs, 1);
    @(posedge clk); #2;
    rst = 0; bus.ch_req = '0;
    @(negedge clk);
    checkOutput("t6 cs after rst", bus.ext_cs, 0);
    checkOutput("t6 oe_n after rst", bus.ext_oe_n, 1);
    checkOutput("t6 we_n after rst", bus.ext_we_n, 1);
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.ch_ack != '0) acks++;
    end
    checkOutput("t6 dropped ack", acks, 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) applyStimulus();
    @(posedge clk); #2;
    rst = 0; bus.cpu_req = 0; bus.ch_req = '0; bus.cs = 0; bus.rw = 1;
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
